// File: rtl/fpu_pkg.sv
// Shared floating-point constants, result classes and IEEE bit-pattern helpers.
// Used by the multiplier post-normalize stage and the RNE rounder.
package fpu_pkg;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 2;
  localparam int FLAG_W   = 3;

  typedef enum logic [2:0] {
    CLS_NAN,
    CLS_INF,
    CLS_ZERO,
    CLS_OVF,
    CLS_UNF,
    CLS_NORM
  } res_cls_e;

  function automatic int fpu_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic logic [63:0] qnan_pat(
    input int ew,
    input int mw
  );
    return (((64'd1 << ew) - 64'd1) << mw)
         | (64'd1 << (mw - 1));
  endfunction

  function automatic logic [63:0] inf_pat(
    input logic sign,
    input int   ew,
    input int   mw
  );
    return ({63'd0, sign} << (ew + mw))
         | (((64'd1 << ew) - 64'd1) << mw);
  endfunction

  function automatic logic [63:0] zero_pat(
    input logic sign,
    input int   ew,
    input int   mw
  );
    return {63'd0, sign} << (ew + mw);
  endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even on a normalized mantissa with guard/sticky.
// Purely combinational; a mantissa carry-out bumps the exponent.
module fpu_round_rne
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic [MANT_WIDTH-1:0]       mant,
  input  logic                        g,
  input  logic                        s,
  input  logic signed [EXP_WIDTH+1:0] exp_in,
  output logic [MANT_WIDTH-1:0]       mant_out,
  output logic signed [EXP_WIDTH+1:0] exp_out
);

  logic                  inc;
  logic [MANT_WIDTH:0]   sum;

  assign inc = g & (s | mant[0]);
  assign sum = {1'b0, mant}
             + {{MANT_WIDTH{1'b0}}, inc};

  // On carry-out the low bits are already all zero.
  assign mant_out = sum[MANT_WIDTH-1:0];
  assign exp_out  = exp_in
                  + {{(EXP_WIDTH+1){1'b0}}, sum[MANT_WIDTH]};

endmodule

// File: rtl/fpu_mul_norm_round.sv
// Multiplier back end: S1 normalizes the raw product, S2 rounds,
// classifies and packs the result, with valid/ready on both sides.
module fpu_mul_norm_round
  import fpu_pkg::*;
#(
  parameter int TOTAL_WIDTH = 32,
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_WIDTH+1:0]     in_exp,
  input  logic [2*MANT_WIDTH+1:0]  in_prod,
  input  logic                     in_nan,
  input  logic                     in_inf,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TOTAL_WIDTH-1:0]   out_result,
  output logic                     out_overflow,
  output logic                     out_underflow,
  output logic                     out_inexact
);

  localparam int SIG_W  = MANT_WIDTH + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int XW     = EXP_WIDTH + 2;

  localparam logic signed [XW-1:0] EXP_MAX =
    {2'b00, {EXP_WIDTH{1'b1}}};

  localparam logic [TOTAL_WIDTH-1:0] QNAN =
    TOTAL_WIDTH'(qnan_pat(EXP_WIDTH, MANT_WIDTH));

  // ---- S1: normalize ----
  logic                  top;
  logic [PROD_W-2:0]     norm;
  logic [MANT_WIDTH-1:0] n_mant;
  logic                  n_g;
  logic                  n_s;
  logic signed [XW-1:0]  n_exp;

  assign top    = in_prod[PROD_W-1];
  assign norm   = top ? in_prod[PROD_W-2:0]
                      : {in_prod[PROD_W-3:0], 1'b0};
  assign n_mant = norm[PROD_W-2 -: MANT_WIDTH];
  assign n_g    = norm[PROD_W-2-MANT_WIDTH];
  assign n_s    = |norm[PROD_W-3-MANT_WIDTH:0];
  assign n_exp  = $signed(in_exp)
                + $signed({{(XW-1){1'b0}}, top});

  logic                  s1_valid;
  logic                  s1_sign;
  logic signed [XW-1:0]  s1_exp;
  logic [MANT_WIDTH-1:0] s1_mant;
  logic                  s1_g;
  logic                  s1_s;
  logic                  s1_nan;
  logic                  s1_inf;
  logic                  s1_zero;

  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= n_exp;
        s1_mant <= n_mant;
        s1_g    <= n_g;
        s1_s    <= n_s;
        s1_nan  <= in_nan;
        s1_inf  <= in_inf;
        s1_zero <= in_zero;
      end
    end
  end

  // ---- S2: round, classify, pack ----
  logic [MANT_WIDTH-1:0] r_mant;
  logic signed [XW-1:0]  r_exp;

  fpu_round_rne #(
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH)
  ) u_rnd (
    .mant     (s1_mant),
    .g        (s1_g),
    .s        (s1_s),
    .exp_in   (s1_exp),
    .mant_out (r_mant),
    .exp_out  (r_exp)
  );

  res_cls_e              cls;
  logic [TOTAL_WIDTH-1:0] nxt_res;
  logic [FLAG_W-1:0]     nxt_flg;

  always_comb begin
    cls = CLS_NORM;
    if (s1_nan)
      cls = CLS_NAN;
    else if (s1_inf)
      cls = CLS_INF;
    else if (s1_zero)
      cls = CLS_ZERO;
    else if (r_exp >= EXP_MAX)
      cls = CLS_OVF;
    else if (r_exp[XW-1] || r_exp == '0)
      cls = CLS_UNF;
  end

  always_comb begin
    nxt_res = '0;
    nxt_flg = '0;
    unique case (cls)
      CLS_NAN:  nxt_res = QNAN;
      CLS_INF:  nxt_res = TOTAL_WIDTH'(
        inf_pat(s1_sign, EXP_WIDTH, MANT_WIDTH));
      CLS_ZERO: nxt_res = TOTAL_WIDTH'(
        zero_pat(s1_sign, EXP_WIDTH, MANT_WIDTH));
      CLS_OVF: begin
        nxt_res = TOTAL_WIDTH'(
          inf_pat(s1_sign, EXP_WIDTH, MANT_WIDTH));
        nxt_flg[FLAG_OVF] = 1'b1;
        nxt_flg[FLAG_INX] = 1'b1;
      end
      CLS_UNF: begin
        nxt_res = TOTAL_WIDTH'(
          zero_pat(s1_sign, EXP_WIDTH, MANT_WIDTH));
        nxt_flg[FLAG_UNF] = 1'b1;
        nxt_flg[FLAG_INX] = 1'b1;
      end
      default: begin
        nxt_res = {s1_sign,
                   r_exp[EXP_WIDTH-1:0],
                   r_mant};
        nxt_flg[FLAG_INX] = s1_g | s1_s;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= nxt_res;
        out_overflow  <= nxt_flg[FLAG_OVF];
        out_underflow <= nxt_flg[FLAG_UNF];
        out_inexact   <= nxt_flg[FLAG_INX];
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_norm_round.sv
// Directed scoreboard bench for the multiplier normalize/round/pack stage.
// Expected packed results are pushed on input transfer, popped on output.
module tb_fpu_mul_norm_round;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic        in_nan;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t exp_cur;
  exp_t e;

  fpu_mul_norm_round #(
    .TOTAL_WIDTH (32),
    .EXP_WIDTH   (8),
    .MANT_WIDTH  (23)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_prod       (in_prod),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .in_zero       (in_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)
        q.push_back(exp_cur);
      if (out_valid && out_ready) begin
        checks++;
        assert (q.size() != 0) else begin
          failures++;
          $error("FAIL sb_empty got=%h", out_result);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          checks++;
          assert (out_result === e.res) else begin
            failures++;
            $error("FAIL sb_result got=%h want=%h",
                   out_result, e.res);
          end
          checks++;
          assert ({out_overflow, out_underflow,
                   out_inexact} ===
                  {e.ovf, e.unf, e.inx}) else begin
            failures++;
            $error("FAIL sb_flags res=%h got=%b want=%b",
                   e.res,
                   {out_overflow, out_underflow, out_inexact},
                   {e.ovf, e.unf, e.inx});
          end
        end
      end
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic set_beat(
    input logic        sg,
    input logic [9:0]  ex,
    input logic [47:0] pr,
    input logic        na,
    input logic        inf,
    input logic        ze,
    input logic [31:0] xr,
    input logic        xo,
    input logic        xu,
    input logic        xi
  );
    in_sign  = sg;
    in_exp   = ex;
    in_prod  = pr;
    in_nan   = na;
    in_inf   = inf;
    in_zero  = ze;
    exp_cur  = '{res: xr, ovf: xo, unf: xu, inx: xi};
    in_valid = 1'b1;
  endtask

  task automatic send(
    input logic        sg,
    input logic [9:0]  ex,
    input logic [47:0] pr,
    input logic        na,
    input logic        inf,
    input logic        ze,
    input logic [31:0] xr,
    input logic        xo,
    input logic        xu,
    input logic        xi
  );
    logic ok;
    ok = 1'b0;
    set_beat(sg, ex, pr, na, inf, ze, xr, xo, xu, xi);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    chk("send_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++)
      @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 32'd0);
  endtask

  logic [31:0] held;
  int          acc;
  int          idx;
  logic [9:0]  st_e [3];
  logic [31:0] st_r [3];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_prod   = '0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    exp_cur   = '0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags",
        {29'd0, out_overflow, out_underflow, out_inexact},
        32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 2.25 with a latency probe
    send(0, 10'd127, 48'h900000000000, 0, 0, 0,
         32'h40100000, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
    drain();

    // back-to-back rounding, range and special cases
    send(0, 10'd127, 48'h400000400000, 0, 0, 0,
         32'h3F800000, 0, 0, 1);
    send(0, 10'd127, 48'h400000C00000, 0, 0, 0,
         32'h3F800002, 0, 0, 1);
    send(0, 10'd127, 48'h400000600000, 0, 0, 0,
         32'h3F800001, 0, 0, 1);
    send(0, 10'd127, 48'h7FFFFFC00000, 0, 0, 0,
         32'h40000000, 0, 0, 1);
    send(0, 10'd254, 48'h800000000000, 0, 0, 0,
         32'h7F800000, 1, 0, 1);
    send(0, 10'd253, 48'hFFFFFF800000, 0, 0, 0,
         32'h7F800000, 1, 0, 1);
    send(0, 10'd253, 48'h800000000000, 0, 0, 0,
         32'h7F000000, 0, 0, 0);
    send(1, 10'd0, 48'h400000000000, 0, 0, 0,
         32'h80000000, 0, 1, 1);
    send(0, 10'h3FB, 48'h800000000000, 0, 0, 0,
         32'h00000000, 0, 1, 1);
    send(0, 10'd0, 48'h800000000000, 0, 0, 0,
         32'h00800000, 0, 0, 0);
    send(1, 10'd127, 48'h800000000000, 1, 0, 0,
         32'h7FC00000, 0, 0, 0);
    send(1, 10'd127, 48'h800000000000, 0, 1, 0,
         32'hFF800000, 0, 0, 0);
    send(1, 10'd254, 48'h800000000000, 0, 0, 1,
         32'h80000000, 0, 0, 0);
    send(0, 10'd127, 48'h800000000000, 1, 1, 0,
         32'h7FC00000, 0, 0, 0);
    in_valid = 1'b0;
    drain();

    // downstream stall with three beats offered
    st_e[0] = 10'd126; st_r[0] = 32'h3F800000;
    st_e[1] = 10'd127; st_r[1] = 32'h40000000;
    st_e[2] = 10'd127; st_r[2] = 32'h40400000;
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    held = '0;
    set_beat(0, st_e[0], 48'h800000000000, 0, 0, 0,
             st_r[0], 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (c == 2) held = out_result;
      if (c == 3) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_stable", out_result, held);
      end
      @(posedge clk);
      #1;
      if (acc > idx) begin
        idx = acc;
        if (idx == 1)
          set_beat(0, st_e[1], 48'h800000000000, 0, 0, 0,
                   st_r[1], 0, 0, 0);
        else if (idx == 2)
          set_beat(0, st_e[2], 48'hC00000000000, 0, 0, 0,
                   st_r[2], 0, 0, 0);
        else
          in_valid = 1'b0;
      end
    end
    chk("stall_accepted", acc, 32'd2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      if (c == 0)
        chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (c == 0) in_valid = 1'b0;
    end
    drain();

    // asynchronous reset with two beats in flight
    send(0, 10'd127, 48'h900000000000, 0, 0, 0,
         32'h40100000, 0, 0, 0);
    send(0, 10'd254, 48'h800000000000, 0, 0, 0,
         32'h7F800000, 1, 0, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", out_result, 32'd0);
    chk("arst_flags",
        {29'd0, out_overflow, out_underflow, out_inexact},
        32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(1, 10'd127, 48'h900000000000, 0, 0, 0,
         32'hC0100000, 0, 0, 0);
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
